// File: rtl/scr1_csr_pkg.sv
// ----------------------------------------------------------------------------
// scr1_csr_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses touched by the sequencer (mstatus, mtvec, mepc, mcause)
//   - mstatus field positions (MIE, MPIE, MPP)
//   - mtvec mode encoding used by the optional vectored target calculation
//   - sequencer state enumeration
// ----------------------------------------------------------------------------
package scr1_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Privilege level written to MPP on trap entry and on mret (machine mode)
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_MEPC   = 3'd1,
        W_MCAUSE = 3'd2,
        R_MSTAT  = 3'd3,
        W_MSTAT  = 3'd4,
        R_TVEC   = 3'd5,
        T_CALC   = 3'd6,
        R_MEPC   = 3'd7
    } trap_state_e;

endpackage

// File: rtl/scr1_trap_ctrl_if.sv
// ----------------------------------------------------------------------------
// scr1_trap_ctrl_if
// CSR file access port driven by the trap sequencer.
//   csr_address_o   : CSR address (12 LSBs meaningful, upper bits zero)
//   csr_en_write_o  : write strobe
//   csr_en_read_o   : read strobe
//   csr_en_except_o : exception-mode qualifier
//   csr_data_o      : write data
//   csr_data_i      : read data, valid the cycle after csr_en_read_o
// Modports: master = trap sequencer, slave = CSR file.
// ----------------------------------------------------------------------------
interface scr1_trap_ctrl_if
    import scr1_csr_pkg::*;
#(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] csr_address_o;
    logic            csr_en_write_o;
    logic            csr_en_read_o;
    logic            csr_en_except_o;
    logic [XLEN-1:0] csr_data_o;
    logic [XLEN-1:0] csr_data_i;

    modport master (
        output csr_address_o,
        output csr_en_write_o,
        output csr_en_read_o,
        output csr_en_except_o,
        output csr_data_o,
        input  csr_data_i
    );

    modport slave (
        input  csr_address_o,
        input  csr_en_write_o,
        input  csr_en_read_o,
        input  csr_en_except_o,
        input  csr_data_o,
        output csr_data_i
    );
endinterface

// File: rtl/scr1_trap_tvec_calc.sv
// ----------------------------------------------------------------------------
// scr1_trap_tvec_calc
// Combinational trap target from mtvec and mcause.
//   mtvec_i  : mtvec value read from the CSR file
//   cause_i  : captured mcause (MSB = interrupt)
//   target_o : new fetch PC
// Build option SCR1_TRAP_VECTORED_EN: when defined, interrupts with
// mtvec mode 01 jump to base + 4*cause; otherwise the target is always base.
// ----------------------------------------------------------------------------
module scr1_trap_tvec_calc
    import scr1_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] cause_i,
    output logic [XLEN-1:0] target_o
);

    logic [XLEN-1:0] base_s;
    logic            unused_s;

    assign base_s = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef SCR1_TRAP_VECTORED_EN
    // Vectored target only for interrupts in vectored mode; sum wraps naturally
    always_comb begin
        target_o = base_s;
        if ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && cause_i[XLEN-1]) begin
            target_o = base_s + {cause_i[XLEN-3:0], 2'b00};
        end else begin
            target_o = base_s;
        end
    end

    assign unused_s = cause_i[XLEN-2];
`else
    assign target_o = base_s;

    // Mode bits and cause do not influence the target in the direct-only build
    assign unused_s = ^{mtvec_i[1:0], cause_i};
`endif

endmodule

// File: rtl/scr1_trap_ctrl.sv
// ----------------------------------------------------------------------------
// scr1_trap_ctrl
// Machine-mode trap sequencer. On a trap request it writes mepc/mcause,
// updates mstatus, reads mtvec and redirects fetch. On mret it reads mepc,
// restores mstatus and redirects to mepc.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   exc_req_i          : trap request (level, sampled in IDLE, wins over mret)
//   exc_cause_i        : mcause value, MSB = interrupt
//   exc_pc_i           : PC of the trapping instruction
//   mret_req_i         : mret request (level, sampled in IDLE)
//   busy_o             : sequence in progress
//   redirect_valid_o   : one-cycle pulse, redirect_pc_o valid
//   redirect_pc_o      : new fetch PC, held until the next redirect
//   csr                : CSR file port (scr1_trap_ctrl_if.master)
// Build option SCR1_TRAP_VECTORED_EN enables vectored interrupt targets
// (see scr1_trap_tvec_calc).
// ----------------------------------------------------------------------------
module scr1_trap_ctrl
    import scr1_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    exc_req_i,
    input  logic [XLEN-1:0]         exc_cause_i,
    input  logic [XLEN-1:0]         exc_pc_i,
    input  logic                    mret_req_i,
    output logic                    busy_o,
    output logic                    redirect_valid_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    scr1_trap_ctrl_if.master        csr
);

    trap_state_e     state_q, state_d;
    logic            mret_q, mret_d;
    logic [XLEN-1:0] cause_q, cause_d;
    // Holds the aligned trap PC on the exception path, the read mepc on mret
    logic [XLEN-1:0] pc_q, pc_d;
    logic            busy_q, busy_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic [XLEN-1:0] tvec_target_s;
    logic [11:0]     csr_addr12_s;
    logic            csr_we_s;
    logic            csr_re_s;
    logic            csr_ex_s;
    logic [XLEN-1:0] csr_wdata_s;

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

    // Trap entry: stash MIE in MPIE, disable interrupts, enter M-mode
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
        return r;
    endfunction

    // mret: restore MIE from MPIE, set MPIE, MPP stays M-mode
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
        return r;
    endfunction

    scr1_trap_tvec_calc #(.XLEN(XLEN)) u_tvec_calc (
        .mtvec_i  (csr.csr_data_i),
        .cause_i  (cause_q),
        .target_o (tvec_target_s)
    );

    // Sequencer next-state, capture registers and redirect generation
    always_comb begin
        state_d          = state_q;
        mret_d           = mret_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            IDLE: begin
                if (exc_req_i) begin
                    state_d = W_MEPC;
                    mret_d  = 1'b0;
                    cause_d = exc_cause_i;
                    pc_d    = align4(exc_pc_i);
                end else if (mret_req_i) begin
                    state_d = R_MEPC;
                    mret_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            W_MEPC:   state_d = W_MCAUSE;
            W_MCAUSE: state_d = R_MSTAT;
            R_MEPC:   state_d = R_MSTAT;
            R_MSTAT: begin
                state_d = W_MSTAT;
                // mepc read in R_MEPC arrives now
                if (mret_q) begin
                    pc_d = align4(csr.csr_data_i);
                end else begin
                    pc_d = pc_q;
                end
            end
            W_MSTAT: begin
                if (mret_q) begin
                    state_d          = IDLE;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = pc_q;
                end else begin
                    state_d = R_TVEC;
                end
            end
            R_TVEC:   state_d = T_CALC;
            T_CALC: begin
                state_d          = IDLE;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = tvec_target_s;
            end
            default:  state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Moore decode of the CSR port; W_MSTAT data is a function of the read data
    always_comb begin
        csr_addr12_s = 12'h000;
        csr_we_s     = 1'b0;
        csr_re_s     = 1'b0;
        csr_ex_s     = 1'b0;
        csr_wdata_s  = {XLEN{1'b0}};
        case (state_q)
            W_MEPC: begin
                csr_addr12_s = CSR_MEPC;
                csr_we_s     = 1'b1;
                csr_wdata_s  = pc_q;
            end
            W_MCAUSE: begin
                csr_addr12_s = CSR_MCAUSE;
                csr_we_s     = 1'b1;
                csr_wdata_s  = cause_q;
            end
            R_MSTAT: begin
                csr_addr12_s = CSR_MSTATUS;
                csr_re_s     = 1'b1;
            end
            W_MSTAT: begin
                csr_addr12_s = CSR_MSTATUS;
                csr_we_s     = 1'b1;
                if (mret_q) begin
                    csr_wdata_s = mstatus_on_mret(csr.csr_data_i);
                end else begin
                    csr_wdata_s = mstatus_on_trap(csr.csr_data_i);
                end
            end
            R_TVEC: begin
                // Reads are allowed in exception mode; writes are not
                csr_addr12_s = CSR_MTVEC;
                csr_re_s     = 1'b1;
                csr_ex_s     = 1'b1;
            end
            R_MEPC: begin
                csr_addr12_s = CSR_MEPC;
                csr_re_s     = 1'b1;
            end
            default: begin
                csr_addr12_s = 12'h000;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            mret_q           <= 1'b0;
            cause_q          <= {XLEN{1'b0}};
            pc_q             <= {XLEN{1'b0}};
            busy_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
        end else begin
            state_q          <= state_d;
            mret_q           <= mret_d;
            cause_q          <= cause_d;
            pc_q             <= pc_d;
            busy_q           <= busy_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign busy_o              = busy_q;
    assign redirect_valid_o    = redirect_valid_q;
    assign redirect_pc_o       = redirect_pc_q;
    assign csr.csr_address_o   = {{(XLEN-12){1'b0}}, csr_addr12_s};
    assign csr.csr_en_write_o  = csr_we_s;
    assign csr.csr_en_read_o   = csr_re_s;
    assign csr.csr_en_except_o = csr_ex_s;
    assign csr.csr_data_o      = csr_wdata_s;

endmodule

// File: tb/tb_scr1_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scr1_trap_ctrl
// Directed bench for scr1_trap_ctrl with a small CSR file model.
// Status vector layout: {busy, redirect_valid, we, re, except, address[31:0]}.
// ----------------------------------------------------------------------------
module tb_scr1_trap_ctrl;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst_i;
    logic            exc_req_i;
    logic [XLEN-1:0] exc_cause_i;
    logic [XLEN-1:0] exc_pc_i;
    logic            mret_req_i;
    logic            busy_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    int total;
    int bad;

    scr1_trap_ctrl_if #(.XLEN(XLEN)) csr_if ();

    scr1_trap_ctrl #(.XLEN(XLEN)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .exc_req_i        (exc_req_i),
        .exc_cause_i      (exc_cause_i),
        .exc_pc_i         (exc_pc_i),
        .mret_req_i       (mret_req_i),
        .busy_o           (busy_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .csr              (csr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: registered read data, preload port for test setup
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, rdata_r;
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    logic [11:0] acc_addr;

    assign csr_if.csr_data_i = rdata_r;
    assign acc_addr = pl_we ? pl_addr : csr_if.csr_address_o[11:0];

    always @(posedge clk) begin
        if (pl_we || csr_if.csr_en_write_o) begin
            case (acc_addr)
                12'h300: m_mstatus <= pl_we ? pl_data : csr_if.csr_data_o;
                12'h305: m_mtvec   <= pl_we ? pl_data : csr_if.csr_data_o;
                12'h341: m_mepc    <= pl_we ? pl_data : csr_if.csr_data_o;
                12'h342: m_mcause  <= pl_we ? pl_data : csr_if.csr_data_o;
                default: ;
            endcase
        end
        if (csr_if.csr_en_read_o) begin
            case (csr_if.csr_address_o[11:0])
                12'h300: rdata_r <= m_mstatus;
                12'h305: rdata_r <= m_mtvec;
                12'h341: rdata_r <= m_mepc;
                12'h342: rdata_r <= m_mcause;
                default: rdata_r <= 32'hDEAD_BEEF;
            endcase
        end else begin
            rdata_r <= 32'h0000_0000;
        end
    end

    function automatic logic [36:0] st(input logic b, input logic v, input logic w,
                                       input logic r, input logic e, input logic [11:0] a);
        return {b, v, w, r, e, 20'h00000, a};
    endfunction

    function automatic logic [36:0] obs_now();
        return {busy_o, redirect_valid_o, csr_if.csr_en_write_o, csr_if.csr_en_read_o,
                csr_if.csr_en_except_o, csr_if.csr_address_o};
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (obs_now() !== 37'h0) begin
            bad++; $display("FAIL reset_status: got %h want %h", obs_now(), 37'h0);
        end
        total++;
        if (redirect_pc_o !== 32'h0 || csr_if.csr_data_o !== 32'h0) begin
            bad++; $display("FAIL reset_pc_data: got pc=%h data=%h want 0/0", redirect_pc_o, csr_if.csr_data_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (obs_now() !== 37'h0) begin
            bad++; $display("FAIL reset_idle: got %h want %h", obs_now(), 37'h0);
        end
    endtask

    task automatic test_exception();
        logic [36:0] es [1:7];
        logic [31:0] ed [1:7];
        es[1] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h341); ed[1] = 32'h0000_0104;
        es[2] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h342); ed[2] = 32'h0000_000B;
        es[3] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300); ed[3] = 32'h0;
        es[4] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300); ed[4] = 32'h0000_1880;
        es[5] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305); ed[5] = 32'h0;
        es[6] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); ed[6] = 32'h0;
        es[7] = st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000); ed[7] = 32'h0;
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_0400);
        exc_cause_i = 32'h0000_000B; exc_pc_i = 32'h0000_0104; exc_req_i = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) exc_req_i = 1'b0;
            total++;
            if (obs_now() !== es[c]) begin
                bad++; $display("FAIL exc_status c%0d: got %h want %h", c, obs_now(), es[c]);
            end
            if (es[c][34]) begin
                total++;
                if (csr_if.csr_data_o !== ed[c]) begin
                    bad++; $display("FAIL exc_wdata c%0d: got %h want %h", c, csr_if.csr_data_o, ed[c]);
                end
            end
        end
        total++;
        if (redirect_pc_o !== 32'h0000_0400) begin
            bad++; $display("FAIL exc_target: got %h want %h", redirect_pc_o, 32'h0000_0400);
        end
        @(negedge clk);
        total++;
        if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0000_0400) begin
            bad++; $display("FAIL exc_hold: got v=%b pc=%h want 0/00000400", redirect_valid_o, redirect_pc_o);
        end
        total++;
        if (m_mstatus !== 32'h0000_1880 || m_mepc !== 32'h0000_0104 || m_mcause !== 32'h0000_000B) begin
            bad++; $display("FAIL exc_csrs: got %h %h %h want 00001880 00000104 0000000b", m_mstatus, m_mepc, m_mcause);
        end
    endtask

    task automatic test_mret();
        logic [36:0] es [1:5];
        es[1] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h341);
        es[2] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300);
        es[3] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300);
        es[4] = st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        es[5] = st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        preload(12'h341, 32'h0000_0104);
        preload(12'h300, 32'h0000_1880);
        mret_req_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) mret_req_i = 1'b0;
            total++;
            if (obs_now() !== es[c]) begin
                bad++; $display("FAIL mret_status c%0d: got %h want %h", c, obs_now(), es[c]);
            end
            if (c == 3) begin
                total++;
                if (csr_if.csr_data_o !== 32'h0000_1888) begin
                    bad++; $display("FAIL mret_wdata: got %h want %h", csr_if.csr_data_o, 32'h0000_1888);
                end
            end
            if (c >= 4) begin
                total++;
                if (redirect_pc_o !== 32'h0000_0104) begin
                    bad++; $display("FAIL mret_target c%0d: got %h want %h", c, redirect_pc_o, 32'h0000_0104);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [36:0] es [1:8];
        logic [31:0] ed [1:8];
        es[1] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h341); ed[1] = 32'h0000_0200;
        es[2] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h342); ed[2] = 32'h0000_0003;
        es[3] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300); ed[3] = 32'h0;
        es[4] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300); ed[4] = 32'h0000_1800;
        es[5] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305); ed[5] = 32'h0;
        es[6] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); ed[6] = 32'h0;
        es[7] = st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000); ed[7] = 32'h0;
        es[8] = st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); ed[8] = 32'h0;
        preload(12'h300, 32'h0000_0000);
        preload(12'h305, 32'h0000_0400);
        exc_cause_i = 32'h0000_0003; exc_pc_i = 32'h0000_0200;
        exc_req_i = 1'b1; mret_req_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin exc_req_i = 1'b0; mret_req_i = 1'b0; end
            total++;
            if (obs_now() !== es[c]) begin
                bad++; $display("FAIL prio_status c%0d: got %h want %h", c, obs_now(), es[c]);
            end
            if (es[c][34]) begin
                total++;
                if (csr_if.csr_data_o !== ed[c]) begin
                    bad++; $display("FAIL prio_wdata c%0d: got %h want %h", c, csr_if.csr_data_o, ed[c]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_0400);
        exc_cause_i = 32'h0000_0001; exc_pc_i = 32'h0000_0104; exc_req_i = 1'b1;
        repeat (3) @(negedge clk);
        exc_req_i = 1'b0;
        total++;
        if (obs_now() !== st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300)) begin
            bad++; $display("FAIL abort_c3: got %h want %h", obs_now(), st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300));
        end
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (obs_now() !== 37'h0 || redirect_pc_o !== 32'h0) begin
            bad++; $display("FAIL abort_c4: got %h pc=%h want 0 pc=0", obs_now(), redirect_pc_o);
        end
        rst_i = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if (obs_now() !== 37'h0) begin
                bad++; $display("FAIL abort_quiet c%0d: got %h want %h", c, obs_now(), 37'h0);
            end
        end
        total++;
        if (m_mstatus !== 32'h0000_0008) begin
            bad++; $display("FAIL abort_mstatus: got %h want %h", m_mstatus, 32'h0000_0008);
        end
    endtask

    task automatic test_vectored();
        logic [31:0] tv [0:2];
        logic [31:0] tc [0:2];
        logic [31:0] tt [0:2];
        tv[0] = 32'h0000_0401; tc[0] = 32'h8000_0007;
`ifdef SCR1_TRAP_VECTORED_EN
        tt[0] = 32'h0000_041C;
`else
        tt[0] = 32'h0000_0400;
`endif
        tv[1] = 32'h0000_0401; tc[1] = 32'h0000_0002; tt[1] = 32'h0000_0400;
        tv[2] = 32'h0000_0403; tc[2] = 32'h8000_0007; tt[2] = 32'h0000_0400;
        for (int k = 0; k < 3; k++) begin
            preload(12'h305, tv[k]);
            exc_cause_i = tc[k]; exc_pc_i = 32'h0000_0300; exc_req_i = 1'b1;
            @(negedge clk);
            exc_req_i = 1'b0;
            repeat (6) @(negedge clk);
            total++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== tt[k]) begin
                bad++; $display("FAIL vec_target%0d: got v=%b pc=%h want 1/%h", k, redirect_valid_o, redirect_pc_o, tt[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] es [1:14];
        logic [31:0] ed [1:14];
        es[1]  = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h341); ed[1]  = 32'h0000_0104;
        es[2]  = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h342); ed[2]  = 32'h0000_0005;
        es[3]  = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300); ed[3]  = 32'h0;
        es[4]  = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300); ed[4]  = 32'h0000_1880;
        es[5]  = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305); ed[5]  = 32'h0;
        es[6]  = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); ed[6]  = 32'h0;
        es[7]  = st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000); ed[7]  = 32'h0;
        es[8]  = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h341); ed[8]  = 32'h0000_0104;
        es[9]  = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h342); ed[9]  = 32'h0000_0005;
        es[10] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h300); ed[10] = 32'h0;
        es[11] = st(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300); ed[11] = 32'h0000_1800;
        es[12] = st(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h305); ed[12] = 32'h0;
        es[13] = st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); ed[13] = 32'h0;
        es[14] = st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000); ed[14] = 32'h0;
        preload(12'h300, 32'h0000_0008);
        preload(12'h305, 32'h0000_0400);
        exc_cause_i = 32'h0000_0005; exc_pc_i = 32'h0000_0107; exc_req_i = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 8) exc_req_i = 1'b0;
            total++;
            if (obs_now() !== es[c]) begin
                bad++; $display("FAIL b2b_status c%0d: got %h want %h", c, obs_now(), es[c]);
            end
            if (es[c][34]) begin
                total++;
                if (csr_if.csr_data_o !== ed[c]) begin
                    bad++; $display("FAIL b2b_wdata c%0d: got %h want %h", c, csr_if.csr_data_o, ed[c]);
                end
            end
        end
        total++;
        if (redirect_pc_o !== 32'h0000_0400 || m_mstatus !== 32'h0000_1800) begin
            bad++; $display("FAIL b2b_end: got pc=%h mstatus=%h want 00000400 00001800", redirect_pc_o, m_mstatus);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_i = 1'b1; exc_req_i = 1'b0; mret_req_i = 1'b0;
        exc_cause_i = 32'h0; exc_pc_i = 32'h0;
        pl_we = 1'b0; pl_addr = 12'h000; pl_data = 32'h0;
        test_reset();
        test_exception();
        test_mret();
        test_priority();
        test_reset_abort();
        test_vectored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
